// File: rtl/adder_seq_pkg.sv
// Shared types and default sizing for the sequential multiword adder.
package adder_seq_pkg;

    // Default slice width (bits) and number of words per operand.
    localparam int unsigned DefaultN = 4;
    localparam int unsigned DefaultW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/word_adder.sv
// N-bit combinational adder slice with carry in and carry out.
module word_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] total;

    // Zero-extend everything to N+1 bits so the carry lands in the top bit.
    always_comb begin
        total = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
        Sum   = total[N-1:0];
        Cout  = total[N];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multiword adder: one shared N-bit slice adds W words, one word per cycle.
// Optional signed-overflow output Ovf is enabled by defining MULTIWORD_ADD_OVF_EN.
module multiword_add_seq
    import adder_seq_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned W = DefaultW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*W-1:0] A,
    input  logic [N*W-1:0] B,
    input  logic           Cin,
    output logic [N*W-1:0] Sum,
    output logic           Cout,
    output logic           busy,
    output logic           done
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    output logic           Ovf
`endif
);

    localparam int unsigned IdxW = $clog2(W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(W - 1);

    state_t         state_q, state_d;
    logic [N*W-1:0] a_q, a_d, b_q, b_d;
    logic [N*W-1:0] sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef MULTIWORD_ADD_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [N-1:0] slice_a, slice_b, slice_s;
    logic         slice_c;

    // Select the operand words addressed by the current word index.
    always_comb begin
        slice_a = a_q[idx_q*N +: N];
        slice_b = b_q[idx_q*N +: N];
    end

    word_adder #(
        .N (N)
    ) u_word_adder (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .Sum  (slice_s),
        .Cout (slice_c)
    );

    // Next-state and registered-output logic for the IDLE/ADD/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[idx_q*N +: N] = slice_s;
                carry_d             = slice_c;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_c;
`ifdef MULTIWORD_ADD_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit.
                    ovf_d   = (slice_a[N-1] ^ slice_b[N-1] ^ slice_s[N-1]) ^ slice_c;
`endif
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef MULTIWORD_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter: N, default 4, word width of the shared adder slice in bits.
REQ-002 Parameter: W, default 4, number of words per operand; W >= 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-006 Port: A  input  N*W  operand A, least-significant word at [N-1:0].
REQ-007 Port: B  input  N*W  operand B, same packing as A.
REQ-008 Port: Cin  input  1  carry into word 0.
REQ-009 Port: Sum  output  N*W  registered result.
REQ-010 Port: Cout  output  1  registered carry out of the top word.
REQ-011 Port: busy  output  1  high in ADD and DONE states.
REQ-012 Port: done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, ADD, DONE.
REQ-014 IDLE, start=1: latch A, B; carry register <= Cin; word index <= 0; go to ADD.
REQ-015 IDLE, start=0: remain in IDLE; Sum and Cout hold their values.
REQ-016 ADD: each cycle, one N-bit slice computes {c, s} = A[i] + B[i] + carry; s is written to Sum word i; carry <= c; i <= i+1.
REQ-017 ADD, i = W-1: Cout <= c; next state DONE.
REQ-018 Latency: start high in cycle 0 -> done high in cycle W+1 only; Sum/Cout valid from cycle W+1.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-020 Sum/Cout hold their values after DONE until the next accepted start.
REQ-021 start while busy=1, including the DONE cycle, is ignored and has no effect.
REQ-022 A, B and Cin changes after acceptance do not affect the in-flight result.
REQ-023 Word-index counter width is $clog2(W); the counter never wraps beyond W-1.
REQ-024 Back-to-back operation: start in the first IDLE cycle after DONE is accepted; minimum period is W+2 cycles.

Reset
REQ-025 reset=1 at a clock edge: state <= IDLE; Sum <= 0; Cout <= 0; carry <= 0; index <= 0; busy=0; done=0.
REQ-026 Reset during ADD or DONE aborts the operation; no done pulse is produced.
REQ-027 reset has priority over start in the same cycle.

Configuration
REQ-028 Macro MULTIWORD_ADD_OVF_EN defined: add output port Ovf (1 bit); it is loaded in the final ADD cycle with the carry into the top bit XOR the carry out of the top bit (signed overflow); reset value 0; it holds with Sum.
REQ-029 MULTIWORD_ADD_OVF_EN undefined: no Ovf port and no overflow logic.

Structure
REQ-030 Package adder_seq_pkg holds the state typedef (IDLE/ADD/DONE) and the default N and W constants.
REQ-031 Sub-module word_adder (N-bit combinational, inputs A, B, Cin; outputs Sum, Cout) is instantiated once and shared across all words.

Verification (N=4, W=4)
REQ-032 A=16'h1234, B=16'h0FFF, Cin=0, start in cycle 0 -> done in cycle 5; Sum=16'h2233; Cout=0.
REQ-033 A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000; Cout=1; with OVF_EN, Ovf=0.
REQ-034 A=16'h7FFF, B=16'h0001, Cin=0, OVF_EN defined -> Sum=16'h8000; Ovf=1; Cout=0.
REQ-035 start re-asserted in cycles 1-5 with different operands -> first result unchanged; exactly one done pulse.
REQ-036 reset in cycle 2 of an operation -> outputs 0, state IDLE, no done; a new start then completes normally.
REQ-037 A=16'h0000, B=16'hFFFF, Cin=1 -> Sum=16'h0000; Cout=1 (carry ripples through all words).
